mem_controller: RTL and testbench

- Sole owner of the byte-wide RAM/IO bus; arbitrates it between three requesters: ROB committed stores, LSB loads and instruction fetch.
- Serialises each 1/2/4-byte access into byte beats, assembles and extends read data, and returns it with its ROB id.
- Drives mem_busy back to the ROB so that no committed store is ever dropped.

---
 rtl/mem_controller.sv | 268 ++++++++++++++++++++++++++
 tb/tb_mem_controller.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_controller.sv
// Byte-wide RAM/IO bus owner: arbitrates committed stores, LSB loads and instruction fetch,
// serialising each access into byte beats and assembling/extending read data.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef INST_OP_WIDTH
`define INST_OP_WIDTH 6
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif

module mem_controller #(
  parameter logic [`XLEN-1:0] IO_ADDR_LO = 32'h30000,
  parameter logic [`XLEN-1:0] IO_ADDR_HI = 32'h30004
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rdy,
  input  logic                       flush,
  input  logic                       io_buffer_full,
  input  logic [7:0]                 mem_din,
  output logic [7:0]                 mem_dout,
  output logic [`XLEN-1:0]           mem_a,
  output logic                       mem_wr,
  input  logic                       rob_mem_enable,
  input  logic [`INST_OP_WIDTH-1:0]  rob_mem_op,
  input  logic [`XLEN-1:0]           rob_mem_addr,
  input  logic [`XLEN-1:0]           rob_mem_val,
  input  logic                       lsb_req,
  input  logic [`INST_OP_WIDTH-1:0]  lsb_op,
  input  logic [`XLEN-1:0]           lsb_addr,
  input  logic [`ROB_SIZE_WIDTH-1:0] lsb_id,
  input  logic                       if_req,
  input  logic [`XLEN-1:0]           if_addr,
  output logic                       mem_busy,
  output logic                       mem_data_ready,
  output logic [`XLEN-1:0]           mem_data,
  output logic [`ROB_SIZE_WIDTH-1:0] mem_id,
  output logic                       if_ready,
  output logic [31:0]                if_inst
);

  localparam int unsigned OpW = `INST_OP_WIDTH;
  localparam int unsigned AW  = `XLEN;
  localparam int unsigned IdW = `ROB_SIZE_WIDTH;

  localparam logic [OpW-1:0] OpLb  = OpW'(0);
  localparam logic [OpW-1:0] OpLh  = OpW'(1);
  localparam logic [OpW-1:0] OpLw  = OpW'(2);
  localparam logic [OpW-1:0] OpLbu = OpW'(3);
  localparam logic [OpW-1:0] OpLhu = OpW'(4);
  localparam logic [OpW-1:0] OpSb  = OpW'(5);
  localparam logic [OpW-1:0] OpSh  = OpW'(6);
  localparam logic [OpW-1:0] OpSw  = OpW'(7);

  typedef enum logic [1:0] {StIdle, StStore, StLoad, StFetch} state_e;

  state_e         state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [2:0]     len_q, len_d;
  logic [AW-1:0]  base_q, base_d;
  logic [OpW-1:0] op_q, op_d;
  logic [IdW-1:0] id_q, id_d;
  logic [31:0]    data_q, data_d;

  logic           pend_valid_q, pend_valid_d;
  logic [OpW-1:0] pend_op_q, pend_op_d;
  logic [AW-1:0]  pend_addr_q, pend_addr_d;
  logic [AW-1:0]  pend_val_q, pend_val_d;

  logic           rd_ready_q, rd_ready_d;
  logic [AW-1:0]  rd_data_q, rd_data_d;
  logic [IdW-1:0] rd_id_q, rd_id_d;
  logic           if_ready_q, if_ready_d;
  logic [31:0]    if_inst_q, if_inst_d;

  logic        grant_ok;
  logic        store_ok, load_ok, fetch_ok;
  logic        pend_is_io;
  logic [31:0] word;

  function automatic logic [2:0] op_len(input logic [OpW-1:0] op);
    logic [2:0] l;
    l = 3'd4;
    if (op == OpLb || op == OpLbu || op == OpSb) l = 3'd1;
    if (op == OpLh || op == OpLhu || op == OpSh) l = 3'd2;
    return l;
  endfunction

  function automatic logic [AW-1:0] extend(input logic [OpW-1:0] op, input logic [31:0] w);
    logic [AW-1:0] r;
    r = AW'(w);
    if (op == OpLb)  r = AW'({{24{w[7]}}, w[7:0]});
    if (op == OpLbu) r = AW'({24'd0, w[7:0]});
    if (op == OpLh)  r = AW'({{16{w[15]}}, w[15:0]});
    if (op == OpLhu) r = AW'({16'd0, w[15:0]});
    return r;
  endfunction

  // IO stores must wait until the IO buffer can take the byte.
  assign pend_is_io = (pend_addr_q == IO_ADDR_LO) || (pend_addr_q == IO_ADDR_HI);
  assign store_ok   = pend_valid_q && !(pend_is_io && io_buffer_full);
  // The finishing requester still holds its request until it sees its pulse; mask it out.
  assign load_ok    = lsb_req && !flush && !rd_ready_q && (state_q != StLoad);
  assign fetch_ok   = if_req && !flush && !if_ready_q && (state_q != StFetch);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      len_q        <= '0;
      base_q       <= '0;
      op_q         <= '0;
      id_q         <= '0;
      data_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_op_q    <= '0;
      pend_addr_q  <= '0;
      pend_val_q   <= '0;
      rd_ready_q   <= 1'b0;
      rd_data_q    <= '0;
      rd_id_q      <= '0;
      if_ready_q   <= 1'b0;
      if_inst_q    <= '0;
    end else if (rdy) begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      base_q       <= base_d;
      op_q         <= op_d;
      id_q         <= id_d;
      data_q       <= data_d;
      pend_valid_q <= pend_valid_d;
      pend_op_q    <= pend_op_d;
      pend_addr_q  <= pend_addr_d;
      pend_val_q   <= pend_val_d;
      rd_ready_q   <= rd_ready_d;
      rd_data_q    <= rd_data_d;
      rd_id_q      <= rd_id_d;
      if_ready_q   <= if_ready_d;
      if_inst_q    <= if_inst_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    base_d       = base_q;
    op_d         = op_q;
    id_d         = id_q;
    data_d       = data_q;
    pend_valid_d = pend_valid_q;
    pend_op_d    = pend_op_q;
    pend_addr_d  = pend_addr_q;
    pend_val_d   = pend_val_q;
    rd_ready_d   = 1'b0;
    rd_data_d    = rd_data_q;
    rd_id_d      = rd_id_q;
    if_ready_d   = 1'b0;
    if_inst_d    = if_inst_q;
    grant_ok     = 1'b0;

    // Byte cnt-1 arrives on mem_din in this cycle.
    word = data_q;
    for (int i = 0; i < 4; i++) begin
      if (cnt_q == 3'(i + 1)) word[8*i +: 8] = mem_din;
    end

    unique case (state_q)
      StIdle: grant_ok = 1'b1;
      StStore: begin
        if (cnt_q == len_q - 3'd1) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StLoad, StFetch: begin
        if (flush) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == len_q) begin
          state_d  = StIdle;
          cnt_d    = '0;
          grant_ok = 1'b1;
          if (state_q == StLoad) begin
            rd_ready_d = 1'b1;
            rd_data_d  = extend(op_q, word);
            rd_id_d    = id_q;
          end else begin
            if_ready_d = 1'b1;
            if_inst_d  = word;
          end
        end else begin
          cnt_d  = cnt_q + 3'd1;
          data_d = word;
        end
      end
      default: ;
    endcase

    if (grant_ok) begin
      if (store_ok) begin
        state_d      = StStore;
        cnt_d        = '0;
        len_d        = op_len(pend_op_q);
        base_d       = pend_addr_q;
        data_d       = pend_val_q[31:0];
        pend_valid_d = 1'b0;
      end else if (load_ok) begin
        state_d = StLoad;
        cnt_d   = '0;
        len_d   = op_len(lsb_op);
        base_d  = lsb_addr;
        op_d    = lsb_op;
        id_d    = lsb_id;
        data_d  = '0;
      end else if (fetch_ok) begin
        state_d = StFetch;
        cnt_d   = '0;
        len_d   = 3'd4;
        base_d  = if_addr;
        op_d    = OpLw;
        data_d  = '0;
      end
    end

    if (rob_mem_enable) begin
      pend_valid_d = 1'b1;
      pend_op_d    = rob_mem_op;
      pend_addr_d  = rob_mem_addr;
      pend_val_d   = rob_mem_val;
    end
  end

  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    unique case (state_q)
      StStore: begin
        mem_a    = base_q + AW'(cnt_q);
        mem_dout = 8'(data_q >> {cnt_q[1:0], 3'b000});
        mem_wr   = rdy;
      end
      StLoad, StFetch: begin
        // Final sampling cycle carries no address so IO ports are never left on the bus.
        if (cnt_q != len_q) mem_a = base_q + AW'(cnt_q);
      end
      default: ;
    endcase
  end

  assign mem_busy       = pend_valid_q | rob_mem_enable | (state_q == StStore);
  assign mem_data_ready = rd_ready_q;
  assign mem_data       = rd_data_q;
  assign mem_id         = rd_id_q;
  assign if_ready       = if_ready_q;
  assign if_inst        = if_inst_q;

  logic unused_ops;
  assign unused_ops = ^{OpSw};

endmodule

// File: tb/tb_mem_controller.sv
// Directed bench for mem_controller: table of loads plus hand sequences for stores,
// arbitration, IO hold, flush, stall and asynchronous reset.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef INST_OP_WIDTH
`define INST_OP_WIDTH 6
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif

module tb_mem_controller;
  localparam logic [5:0] OpLb = 6'd0, OpLh = 6'd1, OpLw = 6'd2, OpLbu = 6'd3, OpLhu = 6'd4;
  localparam logic [5:0] OpSb = 6'd5, OpSh = 6'd6, OpSw = 6'd7;

  logic        clk = 1'b0, rst_n = 1'b0, rdy = 1'b1, flush = 1'b0, io_buffer_full = 1'b0;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        rob_mem_enable = 1'b0;
  logic [5:0]  rob_mem_op = '0;
  logic [31:0] rob_mem_addr = '0, rob_mem_val = '0;
  logic        lsb_req = 1'b0;
  logic [5:0]  lsb_op = '0;
  logic [31:0] lsb_addr = '0;
  logic [3:0]  lsb_id = '0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        mem_busy, mem_data_ready, if_ready;
  logic [31:0] mem_data, if_inst;
  logic [3:0]  mem_id;

  mem_controller dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush), .io_buffer_full(io_buffer_full),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .rob_mem_enable(rob_mem_enable), .rob_mem_op(rob_mem_op), .rob_mem_addr(rob_mem_addr),
    .rob_mem_val(rob_mem_val), .lsb_req(lsb_req), .lsb_op(lsb_op), .lsb_addr(lsb_addr),
    .lsb_id(lsb_id), .if_req(if_req), .if_addr(if_addr), .mem_busy(mem_busy),
    .mem_data_ready(mem_data_ready), .mem_data(mem_data), .mem_id(mem_id),
    .if_ready(if_ready), .if_inst(if_inst)
  );

  always #5 clk = ~clk;

  // Read-only RAM image; writes land in a separate log.
  function automatic logic [7:0] rom(input logic [31:0] a);
    case (a[7:0])
      8'h00: rom = 8'h13;  8'h01: rom = 8'h00;  8'h02: rom = 8'h00;  8'h03: rom = 8'h00;
      8'h20: rom = 8'h80;  8'h21: rom = 8'h7F;  8'h22: rom = 8'h01;  8'h23: rom = 8'hFE;
      8'h40: rom = 8'hEF;  8'h41: rom = 8'hBE;  8'h42: rom = 8'hAD;  8'h43: rom = 8'hDE;
      default: rom = a[7:0];
    endcase
  endfunction

  logic [7:0] wmem [0:255];
  always @(posedge clk) begin
    mem_din <= rom(mem_a);
    if (mem_wr) wmem[mem_a[7:0]] <= mem_dout;
  end

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rob_pulse(input logic [5:0] op, input logic [31:0] a, input logic [31:0] v);
    rob_mem_op = op; rob_mem_addr = a; rob_mem_val = v; rob_mem_enable = 1'b1;
    #1;
    chk("busy_on_pulse", mem_busy, 1);
    step();
    rob_mem_enable = 1'b0;
    #1;
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [3:0]  id;
    logic [31:0] exp;
    int          lat;
  } ld_vec_t;

  ld_vec_t vecs [10];

  initial begin
    int k, kl, kf;
    logic got;
    logic [31:0] val;

    vecs[0] = '{OpLb,  32'h20,       4'd5,  32'hFFFFFF80, 3};
    vecs[1] = '{OpLbu, 32'h20,       4'd5,  32'h00000080, 3};
    vecs[2] = '{OpLh,  32'h20,       4'd3,  32'h00007F80, 4};
    vecs[3] = '{OpLh,  32'h22,       4'd7,  32'hFFFFFE01, 4};
    vecs[4] = '{OpLhu, 32'h22,       4'd7,  32'h0000FE01, 4};
    vecs[5] = '{OpLw,  32'h20,       4'd1,  32'hFE017F80, 6};
    vecs[6] = '{OpLw,  32'h40,       4'd15, 32'hDEADBEEF, 6};
    vecs[7] = '{OpLh,  32'h21,       4'd2,  32'h0000017F, 4};
    vecs[8] = '{OpLb,  32'h23,       4'd4,  32'hFFFFFFFE, 3};
    vecs[9] = '{OpLw,  32'hFFFFFFFF, 4'd6,  32'h000013FF, 6};

    // Reset state
    #3;
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_dout", mem_dout, 0);
    chk("rst_busy", mem_busy, 0);
    chk("rst_ready", mem_data_ready, 0);
    chk("rst_if_ready", if_ready, 0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // SW on an idle bus
    val = 32'h11223344;
    rob_pulse(OpSw, 32'h100, val);
    chk("sw_busy_pend", mem_busy, 1);
    chk("sw_no_wr_yet", mem_wr, 0);
    for (int b = 0; b < 4; b++) begin
      step();
      chk("sw_wr", mem_wr, 1);
      chk("sw_addr", mem_a, 32'h100 + b);
      chk("sw_dout", mem_dout, (val >> (8 * b)) & 32'hFF);
      chk("sw_busy", mem_busy, 1);
    end
    step();
    chk("sw_end_wr", mem_wr, 0);
    chk("sw_end_busy", mem_busy, 0);
    chk("sw_end_addr", mem_a, 0);

    // Load vector table
    for (int v = 0; v < 10; v++) begin
      lsb_op = vecs[v].op; lsb_addr = vecs[v].addr; lsb_id = vecs[v].id; lsb_req = 1'b1;
      k = 0; got = 1'b0;
      while (!got && k < 12) begin
        step();
        k++;
        if (mem_data_ready) got = 1'b1;
      end
      chk("ld_latency", k, vecs[v].lat);
      chk("ld_data", mem_data, vecs[v].exp);
      chk("ld_id", mem_id, 32'(vecs[v].id));
      lsb_req = 1'b0;
      step();
      chk("ld_pulse_once", mem_data_ready, 0);
    end

    // Load beats fetch; fetch granted on the load's final cycle
    lsb_op = OpLw; lsb_addr = 32'h40; lsb_id = 4'd9; lsb_req = 1'b1;
    if_addr = 32'h0; if_req = 1'b1;
    kl = 0; kf = 0;
    for (int c = 1; c <= 15 && kf == 0; c++) begin
      step();
      if (mem_data_ready && kl == 0) begin
        kl = c;
        chk("arb_ld_data", mem_data, 32'hDEADBEEF);
        chk("arb_ld_id", mem_id, 9);
        lsb_req = 1'b0;
      end
      if (c == 7) chk("arb_fetch_beat1", mem_a, 32'h1);
      if (if_ready) begin
        kf = c;
        chk("arb_inst", if_inst, 32'h00000013);
      end
    end
    if_req = 1'b0;
    chk("arb_ld_cycle", kl, 6);
    chk("arb_if_cycle", kf, 11);
    step();

    // IO store held while buffer full
    io_buffer_full = 1'b1;
    rob_pulse(OpSb, 32'h30000, 32'h000000A5);
    for (int c = 0; c < 6; c++) begin
      chk("io_hold_wr", mem_wr, 0);
      chk("io_hold_busy", mem_busy, 1);
      step();
    end
    io_buffer_full = 1'b0;
    #1;
    chk("io_release_wr", mem_wr, 0);
    step();
    chk("io_wr", mem_wr, 1);
    chk("io_addr", mem_a, 32'h30000);
    chk("io_dout", mem_dout, 32'hA5);
    step();
    chk("io_end_wr", mem_wr, 0);
    chk("io_end_addr", mem_a, 0);
    chk("io_end_busy", mem_busy, 0);

    // Flush in cycle 2 of an LW, with a store pulse in the same cycle
    lsb_op = OpLw; lsb_addr = 32'h40; lsb_id = 4'd2; lsb_req = 1'b1;
    step(); step(); step();
    chk("fl_beat2_addr", mem_a, 32'h42);
    flush = 1'b1;
    rob_mem_op = OpSw; rob_mem_addr = 32'h80; rob_mem_val = 32'h55667788; rob_mem_enable = 1'b1;
    step();
    flush = 1'b0; rob_mem_enable = 1'b0; lsb_req = 1'b0;
    #1;
    chk("fl_no_ready", mem_data_ready, 0);
    chk("fl_addr_zero", mem_a, 0);
    chk("fl_busy", mem_busy, 1);
    chk("fl_no_wr", mem_wr, 0);
    for (int b = 0; b < 4; b++) begin
      step();
      chk("fl_st_wr", mem_wr, 1);
      chk("fl_st_addr", mem_a, 32'h80 + b);
      chk("fl_no_ready_later", mem_data_ready, 0);
    end
    step();
    chk("fl_st_byte0", wmem[8'h80], 32'h88);
    chk("fl_st_byte3", wmem[8'h83], 32'h55);

    // rdy low freezes a store and gates mem_wr
    rob_pulse(OpSh, 32'h200, 32'h0000BEEF);
    step();
    chk("rdy_beat0_addr", mem_a, 32'h200);
    rdy = 1'b0;
    #1;
    chk("rdy_gate_wr", mem_wr, 0);
    step();
    chk("rdy_frozen_addr", mem_a, 32'h200);
    rdy = 1'b1;
    #1;
    chk("rdy_resume_wr", mem_wr, 1);
    step();
    chk("rdy_beat1_addr", mem_a, 32'h201);
    chk("rdy_beat1_dout", mem_dout, 32'hBE);
    step();
    chk("rdy_end_wr", mem_wr, 0);

    // Asynchronous reset mid-store drops a pending store too
    rob_pulse(OpSw, 32'h300, 32'hCAFEF00D);
    step(); step();
    rob_mem_op = OpSb; rob_mem_addr = 32'h400; rob_mem_val = 32'h77; rob_mem_enable = 1'b1;
    step();
    rob_mem_enable = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_wr", mem_wr, 0);
    chk("arst_addr", mem_a, 0);
    chk("arst_dout", mem_dout, 0);
    chk("arst_busy", mem_busy, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("arst_idle_wr", mem_wr, 0);
      chk("arst_idle_busy", mem_busy, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
